// File: rtl/demux_1_to_4_4_bit_if.sv
// demux_1_to_4_4_bit_if: bus bundle between the demux and its producer/consumers.
interface demux_1_to_4_4_bit_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] In;
  logic [1:0]       sel;
  logic             rr_mode;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       dst;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3;
  logic [3:0]       vld;
  logic [3:0]       ack;
  modport master (output In, sel, rr_mode, in_valid, ack, input in_ready, dst, Y0, Y1, Y2, Y3, vld);
  modport slave (input In, sel, rr_mode, in_valid, ack, output in_ready, dst, Y0, Y1, Y2, Y3, vld);
endinterface

// File: rtl/demux_1_to_4_4_bit.sv
// demux_1_to_4_4_bit: registered 1-to-4 demux with per-channel valid/ack buffers and round-robin option.
module demux_1_to_4_4_bit #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  demux_1_to_4_4_bit_if.slave bus
);
  logic [1:0]       rr_q, rr_d, dst;
  logic [3:0]       vld_q, vld_d;
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic             rdy, acc;
  always_comb begin
    dst = bus.rr_mode ? rr_q : bus.sel;
    rdy = ~vld_q[dst] | bus.ack[dst];
    acc = bus.in_valid & rdy;
    rr_d = (acc & bus.rr_mode) ? rr_q + 2'd1 : rr_q;
    vld_d = vld_q;
    y_d = y_q;
    // an accept wins over an ack on the same channel so vld stays set
    for (int i = 0; i < 4; i++) begin
      vld_d[i] = (acc && dst == 2'(i)) ? 1'b1 : vld_q[i] & ~bus.ack[i];
      y_d[i] = (acc && dst == 2'(i)) ? bus.In : y_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      vld_q <= '0;
      y_q <= '{default: '0};
    end else begin
      rr_q <= rr_d;
      vld_q <= vld_d;
      y_q <= y_d;
    end
  end
  assign bus.dst = dst;
  assign bus.in_ready = rdy;
  assign bus.vld = vld_q;
  assign bus.Y0 = y_q[0];
  assign bus.Y1 = y_q[1];
  assign bus.Y2 = y_q[2];
  assign bus.Y3 = y_q[3];
endmodule
